// File: rtl/dc_pkg.sv
// Shared DC-path types and helpers for the TX bias injector and the RX decoupler.
// Functions work on 32-bit containers with the active width passed in, so any SYMBOL_WIDTH up to 32 bits can use them.
package dc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RUN,
    RAMP_DOWN
  } dc_state_t;

  // 1.0 in the default Q2.14 sample format
  localparam logic signed [15:0] SYMBOL_ONE = 16'sh4000;

  function automatic logic signed [31:0] saturate(input logic signed [32:0] x, input int unsigned w);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (w - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (w - 1));
    if (x > hi) return 32'(hi);
    if (x < lo) return 32'(lo);
    return 32'(x);
  endfunction

  function automatic logic [31:0] offset_binary(input logic [31:0] x, input int unsigned w);
    return x ^ (32'd1 << (w - 1));
  endfunction

endpackage

// File: rtl/bias_slew.sv
// Slew-limited DC bias register: moves at most RAMP_STEP LSBs toward target per step.
// bias_next is the combinational post-step value; the register only updates when step is high.
module bias_slew #(
  parameter int W         = 16,
  parameter int RAMP_STEP = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step,
  input  logic signed [W-1:0] target,
  output logic signed [W-1:0] bias_next,
  output logic                reached
);

  localparam logic signed [W:0] STEP_MAX = (W+1)'(RAMP_STEP);

  logic signed [W-1:0] bias;
  logic signed [W:0]   diff;
  logic signed [W:0]   delta;

  // One extra bit keeps target - bias from wrapping across the rails.
  always_comb begin
    diff  = {target[W-1], target} - {bias[W-1], bias};
    delta = diff;
    if (diff > STEP_MAX)
      delta = STEP_MAX;
    else if (diff < -STEP_MAX)
      delta = -STEP_MAX;
    bias_next = W'({bias[W-1], bias} + delta);
    reached   = (bias_next == target);
  end

  always_ff @(posedge clk) begin
    if (rst)
      bias <= '0;
    else if (step)
      bias <= bias_next;
  end

endmodule

// File: rtl/dc_bias_inject.sv
// TX DC bias injector / DAC formatter: slewed bias + gated AC, saturate, offset-binary, 2 enabled clocks to dac_code.
// Optional DC_INJECT_DITHER_EN adds LFSR dither below the DAC LSB before truncation (forced off in IDLE).
module dc_bias_inject
  import dc_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 16,
  parameter int SYMBOL_FRAC  = 14,
  parameter int DAC_WIDTH    = 12,
  parameter int RAMP_STEP    = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           new_sample,
  input  logic signed [SYMBOL_WIDTH-1:0] sample,
  input  logic signed [SYMBOL_WIDTH-1:0] bias_target,
  input  logic                           tx_on,
  output logic [DAC_WIDTH-1:0]           dac_code,
  output logic                           dac_valid,
  output logic                           ramping
);

  localparam int SW = SYMBOL_WIDTH;
  localparam int DW = DAC_WIDTH;
  localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};

  if ((DW > SW) || (SYMBOL_FRAC >= SW)) begin : g_cfg_check
    $error("dc_bias_inject: need DAC_WIDTH <= SYMBOL_WIDTH and SYMBOL_FRAC < SYMBOL_WIDTH");
  end

  logic               accept;
  dc_state_t          state_q;
  dc_state_t          state_d;
  logic signed [SW-1:0] slew_target;
  logic signed [SW-1:0] bias_next;
  logic               reached;
  logic signed [SW-1:0] ac;
  logic signed [SW:0] sum_w;
  logic signed [SW-1:0] sat;
  logic signed [SW-1:0] sat_q;
  logic               stage1_vld;
  logic               out_vld;
  logic [SW-1:0]      ob;
  logic [SW-1:0]      ob_out;
  logic [DW-1:0]      code_next;

  assign accept = en & new_sample;

  // Slewing toward the target of the mode being entered lets the keying sample itself take the first step.
  assign slew_target = tx_on ? bias_target : '0;

  bias_slew #(
    .W         (SW),
    .RAMP_STEP (RAMP_STEP)
  ) u_bias_slew (
    .clk       (clk),
    .rst       (rst),
    .step      (accept),
    .target    (slew_target),
    .bias_next (bias_next),
    .reached   (reached)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tx_on) state_d = RAMP_UP;
      RAMP_UP:   if (!tx_on) state_d = RAMP_DOWN; else if (reached) state_d = RUN;
      RUN:       if (!tx_on) state_d = RAMP_DOWN;
      RAMP_DOWN: if (tx_on) state_d = RAMP_UP; else if (reached) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else if (accept)
      state_q <= state_d;
  end

  assign ac    = ((state_q == RUN) && tx_on) ? sample : '0;
  assign sum_w = {ac[SW-1], ac} + {bias_next[SW-1], bias_next};
  assign sat   = SW'(saturate(33'(sum_w), SW));
  assign ob    = SW'(offset_binary(32'(sat_q), SW));

`ifdef DC_INJECT_DITHER_EN
  localparam int DITH_W = SW - DW;

  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic [DITH_W-1:0] dither;
  logic [SW:0]       ob_dith;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign dither  = (state_q == IDLE) ? '0 : lfsr[DITH_W-1:0];
  assign ob_dith = {1'b0, ob} + {{(SW+1-DITH_W){1'b0}}, dither};
  assign ob_out  = ob_dith[SW] ? '1 : ob_dith[SW-1:0];

  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= 16'hACE1;
    else if (accept)
      lfsr <= {lfsr[14:0], lfsr_fb};
  end
`else
  assign ob_out = ob;
`endif

  assign code_next = DW'(ob_out >> (SW - DW));

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q      <= '0;
      stage1_vld <= 1'b0;
      out_vld    <= 1'b0;
      dac_code   <= MIDSCALE;
    end else if (en) begin
      stage1_vld <= new_sample;
      if (new_sample)
        sat_q <= sat;
      out_vld <= stage1_vld;
      if (stage1_vld)
        dac_code <= code_next;
    end
  end

  // out_vld holds through a stall and is only shown on an enabled cycle, so each code is flagged exactly once.
  assign dac_valid = out_vld & en;
  assign ramping   = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule

// File: tb/tb_dc_bias_inject.sv
// Directed bench for dc_bias_inject: expected DAC codes are queued as samples are driven and checked when dac_valid fires.
module tb_dc_bias_inject;
  import dc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        new_sample;
  logic        tx_on;
  logic [15:0] sample;
  logic [15:0] bias_target;
  logic [11:0] dac_code;
  logic        dac_valid;
  logic        ramping;

  logic [11:0] exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dc_bias_inject #(
    .SYMBOL_WIDTH (16),
    .SYMBOL_FRAC  (14),
    .DAC_WIDTH    (12),
    .RAMP_STEP    (1024)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .new_sample  (new_sample),
    .sample      (sample),
    .bias_target (bias_target),
    .tx_on       (tx_on),
    .dac_code    (dac_code),
    .dac_valid   (dac_valid),
    .ramping     (ramping)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock, look at outputs 1 time unit after the edge, retire any produced code.
  task automatic tick();
    @(posedge clk);
    #1;
    if (dac_valid === 1'b1) begin
      n_assert++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL unexpected_valid: observed code 0x%0h with valid, expected no output", dac_code);
      end
      if (exp_q.size() != 0)
        chk("dac_code", {4'h0, dac_code}, {4'h0, exp_q.pop_front()});
    end
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] s, input logic [11:0] expected);
    sample     = s;
    new_sample = 1'b1;
    exp_q.push_back(expected);
    tick();
    new_sample = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b1;
    new_sample  = 1'b0;
    tx_on       = 1'b0;
    sample      = '0;
    bias_target = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_code", {4'h0, dac_code}, 16'h0800);
    chk("reset_valid", {15'd0, dac_valid}, 16'd0);
    chk("reset_ramping", {15'd0, ramping}, 16'd0);

`ifndef DC_INJECT_DITHER_EN
    // Soft start: 8 steps of 0x400 up to 0x2000 with AC gated.
    tx_on       = 1'b1;
    bias_target = 16'h2000;
    for (int i = 1; i <= 8; i++) begin
      send(SYMBOL_ONE, 12'h800 + 12'(64 * i));
      chk("ramp_up_ramping", {15'd0, ramping}, (i < 8) ? 16'd1 : 16'd0);
    end
    drain(2);

    // Run: AC passes; output valid exactly two clocks after the strobe.
    send(SYMBOL_ONE, 12'hE00);
    chk("run_valid_1clk", {15'd0, dac_valid}, 16'd0);
    tick();
    chk("run_valid_2clk", {15'd0, dac_valid}, 16'd1);
    chk("run_retired", 16'(exp_q.size()), 16'd0);

    // Saturation at both rails, with a slewed target change while running.
    send(16'h7000, 12'hFFF);
    bias_target = 16'hE000;
    for (int i = 1; i <= 16; i++) send(16'h0000, 12'hA00 - 12'(64 * i));
    send(16'h9000, 12'h000);
    bias_target = 16'h2000;
    for (int i = 1; i <= 16; i++) send(16'h0000, 12'h600 + 12'(64 * i));
    drain(2);

    // Soft stop: AC gated immediately, bias walks back to zero.
    tx_on = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      send(SYMBOL_ONE, 12'hA00 - 12'(64 * i));
      chk("ramp_down_ramping", {15'd0, ramping}, (i < 8) ? 16'd1 : 16'd0);
    end
    send(SYMBOL_ONE, 12'h800);

    // Re-key during ramp-down once bias has come back to 0x1000.
    tx_on = 1'b1;
    for (int i = 1; i <= 6; i++) send(16'h0000, 12'h800 + 12'(64 * i));
    tx_on = 1'b0;
    send(16'h0000, 12'h940);
    send(16'h0000, 12'h900);
    chk("rekey_down_ramping", {15'd0, ramping}, 16'd1);
    tx_on = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(16'h0000, 12'h900 + 12'(64 * i));
      chk("rekey_up_ramping", {15'd0, ramping}, (i < 4) ? 16'd1 : 16'd0);
    end
    drain(2);

    // Stall between a strobe and its output.
    send(16'h1000, 12'hB00);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", {15'd0, dac_valid}, 16'd0);
      chk("stall_hold", {4'h0, dac_code}, 16'h0A00);
    end
    en = 1'b1;
    tick();
    chk("stall_retired", 16'(exp_q.size()), 16'd0);
    tick();
    chk("stall_no_dup", {15'd0, dac_valid}, 16'd0);

    // Reset with a sample in flight: flushed, midscale, ramp restarts from zero bias.
    sample     = SYMBOL_ONE;
    new_sample = 1'b1;
    tick();
    new_sample = 1'b0;
    rst        = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_code", {4'h0, dac_code}, 16'h0800);
    chk("midrst_valid", {15'd0, dac_valid}, 16'd0);
    chk("midrst_ramping", {15'd0, ramping}, 16'd0);
    drain(3);
    send(16'h0000, 12'h840);
    chk("midrst_restart_ramping", {15'd0, ramping}, 16'd1);
    drain(2);
`else
    // Dither in IDLE must leave the output exactly at midscale.
    for (int i = 0; i < 8; i++) begin
      send(SYMBOL_ONE, 12'h800);
      chk("dither_idle_ramping", {15'd0, ramping}, 16'd0);
    end
    drain(2);
`endif

    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
